// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory fetch port plus the decoded fields driven into the store stage
interface fetch_decode_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [15:0] instruction;
  logic [31:0] Read_register1;
  logic [31:0] Read_register2;
  logic        write_enable;
  modport master (
    output imem_addr, imem_req, instruction, Read_register1, Read_register2, write_enable,
    input  imem_valid, imem_rdata
  );
  modport slave (
    input  imem_addr, imem_req, instruction, Read_register1, Read_register2, write_enable,
    output imem_valid, imem_rdata
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: FETCH/DECODE/EXEC/MEM sequencer for SW/LW; define PERF_CNT_EN to build retired/stall counters
module fetch_decode_ctrl #(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  fetch_decode_if.master bus,
  output logic           busy,
  output logic           illegal,
  output logic           timeout,
  output logic [15:0]    retired_cnt,
  output logic [15:0]    stall_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;
  state_t      state;
  logic [31:0] pc, ir, pc_next;
  logic [7:0]  wait_cnt;
  logic        is_sw, is_lw, is_nop;
  assign pc_next = {pc[31:2] + 30'd1, pc[1:0]};
  assign is_sw = ir[31:26] == 6'h2B;
  assign is_lw = ir[31:26] == 6'h23;
  assign is_nop = ir == 32'h0;
  assign bus.imem_addr = pc;
  // sequencer: one state per cycle; outputs change on the same edges as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= PC_RESET;
      ir <= '0;
      wait_cnt <= '0;
      bus.imem_req <= 1'b0;
      bus.instruction <= '0;
      bus.Read_register1 <= '0;
      bus.Read_register2 <= '0;
      bus.write_enable <= 1'b0;
      busy <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state <= FETCH;
          bus.imem_req <= 1'b1;
          busy <= 1'b1;
          wait_cnt <= '0;
        end
        FETCH: if (bus.imem_valid) begin
          ir <= bus.imem_rdata;
          bus.imem_req <= 1'b0;
          state <= DECODE;
        end else if (wait_cnt == 8'(FETCH_TIMEOUT - 1)) begin
          timeout <= 1'b1;
          bus.imem_req <= 1'b0;
          busy <= 1'b0;
          state <= HALT;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        DECODE: begin
          bus.instruction <= ir[15:0];
          bus.Read_register1 <= {27'd0, ir[25:21]};
          bus.Read_register2 <= {27'd0, ir[20:16]};
          if (is_sw || is_lw) begin
            state <= EXEC;
          end else begin
            illegal <= illegal | ~is_nop;
            pc <= pc_next;
            state <= run ? FETCH : IDLE;
            bus.imem_req <= run;
            busy <= run;
            wait_cnt <= '0;
          end
        end
        EXEC: begin
          bus.write_enable <= is_sw;
          state <= MEM;
        end
        MEM: begin
          bus.write_enable <= 1'b0;
          pc <= pc_next;
          state <= run ? FETCH : IDLE;
          bus.imem_req <= run;
          busy <= run;
          wait_cnt <= '0;
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PERF_CNT_EN
  logic retire, stall;
  assign retire = state == MEM || (state == DECODE && is_nop);
  assign stall = state == FETCH && !bus.imem_valid;
  // retire and fetch-stall counters, free-running modulo 2^16
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + {15'd0, retire};
      stall_cnt <= stall_cnt + {15'd0, stall};
    end
  end
`else
  assign retired_cnt = 16'h0;
  assign stall_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl: random fetch stimulus with a scoreboard monitor against an instruction-level model
module tb_fetch_decode_ctrl;
  localparam logic [31:0] PC_RST = 32'hFFFF_FFF9;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic busy, illegal, timeout;
  logic [15:0] retired_cnt, stall_cnt;
  fetch_decode_if bus();
  fetch_decode_ctrl #(.PC_RESET(PC_RST), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus), .busy(busy), .illegal(illegal),
    .timeout(timeout), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );
  typedef struct {logic [31:0] addr; logic [31:0] word; int vcyc;} rec_t;
  rec_t q[$];
  rec_t cur;
  bit have = 0, run_end = 0, exp_ill = 0;
  int cyc = 0, total = 0, passes = 0, d = 0;
  logic [31:0] model_pc = PC_RST;
  logic [15:0] m_ret = 0, m_stall = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask
  function automatic bit is_mem(input logic [31:0] w);
    return w[31:26] == 6'h2B || w[31:26] == 6'h23;
  endfunction
  function automatic bit is_sw(input logic [31:0] w);
    return w[31:26] == 6'h2B;
  endfunction
  function automatic bit is_ill(input logic [31:0] w);
    return !is_mem(w) && w != 32'h0;
  endfunction
  function automatic int end_d(input logic [31:0] w);
    return is_mem(w) ? 3 : 1;
  endfunction
  function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction
  function automatic logic [31:0] rand_word();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 4);
    logic [5:0] op = 6'($urandom);
    if (op == 6'h2B || op == 6'h23) op = 6'h3F;
    return k == 0 ? {6'h2B, r[25:0]} : k == 1 ? {6'h23, r[25:0]} : k == 2 ? 32'h0 : k == 3 ? {op, r[25:0]} : r;
  endfunction
  // monitor: pops the expected instruction on each fetch completion and follows it to retirement
  always @(negedge clk) begin
    if (have) begin
      d = cyc - cur.vcyc;
      if (d == 2) begin
        check("rs", bus.Read_register1, {27'd0, cur.word[25:21]});
        check("rt", bus.Read_register2, {27'd0, cur.word[20:16]});
        check("imm", {16'd0, bus.instruction}, {16'd0, cur.word[15:0]});
        check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
      end
      if (d >= 1 && d <= end_d(cur.word)) check("busy_in_flight", {31'd0, busy}, 32'd1);
      if (d == end_d(cur.word)) run_end = run;
      if (d == end_d(cur.word) + 1) begin
        if (run_end) begin
          check("next_req", {31'd0, bus.imem_req}, 32'd1);
          check("next_addr", bus.imem_addr, cur.addr + 32'd4);
        end else begin
          check("idle_busy", {31'd0, busy}, 32'd0);
          check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        end
        have = 0;
      end
    end
    check("write_enable", {31'd0, bus.write_enable}, {31'd0, have && is_sw(cur.word) && d == 3});
    if (bus.imem_req && bus.imem_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL accept: unexpected fetch completion at cycle %0d", cyc);
      end else begin
        cur = q.pop_front();
        check("fetch_addr", bus.imem_addr, cur.addr);
        exp_ill = exp_ill | is_ill(cur.word);
        have = 1;
      end
    end
    if (reset) begin
      have = 0;
      exp_ill = 0;
      q.delete();
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] w, input int delay);
    int n = 0;
    rec_t r;
    while (!bus.imem_req && n < 100) begin
      bus.imem_valid = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      step();
      n++;
    end
    bus.imem_valid = 1'b0;
    if (!bus.imem_req) begin
      total++;
      $display("FAIL fetch_wait: imem_req not seen within 100 cycles at cycle %0d", cyc);
      return;
    end
    repeat (delay) step();
    bus.imem_valid = 1'b1;
    bus.imem_rdata = w;
    r.addr = model_pc;
    r.word = w;
    r.vcyc = cyc;
    q.push_back(r);
    model_pc = model_pc + 32'd4;
    m_stall = m_stall + 16'(delay);
    if (!is_ill(w)) m_ret = m_ret + 16'd1;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, bus.write_enable}, 32'd0);
    check({tag, "_addr"}, bus.imem_addr, PC_RST);
    check({tag, "_imm"}, {16'd0, bus.instruction}, 32'd0);
    check({tag, "_rs"}, bus.Read_register1, 32'd0);
    check({tag, "_rt"}, bus.Read_register2, 32'd0);
    check({tag, "_retired"}, {16'd0, retired_cnt}, 32'd0);
    check({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
    model_pc = PC_RST;
    m_ret = 0;
    m_stall = 0;
  endtask
  task automatic counter_checks(input string tag);
    check({tag, "_retired"}, {16'd0, retired_cnt}, {16'd0, exp_cnt(m_ret)});
    check({tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, exp_cnt(m_stall)});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    repeat (3) step();
    reset_checks("reset");
    reset = 1'b0;
    repeat (3) begin
      step();
      check("idle_hold_busy", {31'd0, busy}, 32'd0);
      check("idle_hold_req", {31'd0, bus.imem_req}, 32'd0);
    end
    run = 1'b1;
    issue(32'hAC22_0010, 0);
    issue(32'hAC65_1234, 3);
    issue(32'hFC00_0000, 0);
    issue(32'h0000_0000, 0);
    issue(32'h8C43_FFFC, 0);
    run = 1'b0;
    repeat (4) step();
    counter_checks("directed");
    for (int i = 0; i < 150; i++) begin
      run = 1'b1;
      issue(rand_word(), $urandom_range(0, 19) == 0 ? 14 : $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        run = 1'b0;
        repeat ($urandom_range(1, 6)) step();
      end
    end
    run = 1'b0;
    repeat (6) step();
    counter_checks("random");
    check("random_busy", {31'd0, busy}, 32'd0);
    run = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    repeat (14) step();
    check("pre_timeout_req", {31'd0, bus.imem_req}, 32'd1);
    check("pre_timeout_flag", {31'd0, timeout}, 32'd0);
    step();
    m_stall = m_stall + 16'd15;
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    check("timeout_req", {31'd0, bus.imem_req}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hAC22_0010;
    repeat (5) step();
    bus.imem_valid = 1'b0;
    check("halt_timeout", {31'd0, timeout}, 32'd1);
    check("halt_req", {31'd0, bus.imem_req}, 32'd0);
    check("halt_busy", {31'd0, busy}, 32'd0);
    counter_checks("halt");
    reset = 1'b1;
    step();
    reset_checks("post_halt");
    reset = 1'b0;
    issue(32'hAC85_0004, 1);
    step();
    step();
    check("mem_we", {31'd0, bus.write_enable}, 32'd1);
    reset = 1'b1;
    run = 1'b0;
    step();
    reset_checks("mem_reset");
    reset = 1'b0;
    run = 1'b1;
    issue(32'h8C43_FFFC, 0);
    run = 1'b0;
    repeat (4) step();
    check("lw_imm", {16'd0, bus.instruction}, 32'h0000_FFFC);
    check("lw_rs", bus.Read_register1, 32'd2);
    check("lw_addr", bus.imem_addr, PC_RST + 32'd4);
    check("lw_busy", {31'd0, busy}, 32'd0);
    counter_checks("lw");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
